// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg: shared types for the OBI memory responder.
package cv32e40p_pkg;
  typedef enum logic {IDLE, WAIT} gnt_state_e;
  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
  } obi_rsp_t;
endpackage

// File: rtl/cv32e40p_obi_mem_responder_if.sv
// cv32e40p_obi_mem_responder_if: OBI request/response bus plus the grant-stall hook.
interface cv32e40p_obi_mem_responder_if;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        gnt_stall_i;
  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, gnt_stall_i,
    input  gnt_o, rvalid_o, rdata_o
  );
  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, gnt_stall_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/cv32e40p_be_ram.sv
// cv32e40p_be_ram: single-port byte-enabled word RAM, write-first, no reset.
module cv32e40p_be_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  logic [31:0] merged;
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign merged[8*b +: 8] = be[b] ? wdata[8*b +: 8] : mem[addr][8*b +: 8];
  end
  assign rdata = we ? merged : mem[addr];
  always_ff @(posedge clk_i) begin
    if (we) mem[addr] <= merged;
  end
endmodule

// File: rtl/cv32e40p_obi_mem_responder.sv
// cv32e40p_obi_mem_responder: OBI memory model with configurable grant wait and
// fixed-latency in-order responses.
module cv32e40p_obi_mem_responder
  import cv32e40p_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int GNT_WAIT   = 0,
  parameter int RVALID_LAT = 1
) (
  input logic                         clk_i,
  input logic                         rst_ni,
  cv32e40p_obi_mem_responder_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [2:0] LAST = 3'(GNT_WAIT - 1);
  gnt_state_e  state_q, state_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic        gnt, acc, in_range;
  logic [31:0] ram_rdata;
  obi_rsp_t    pipe [RVALID_LAT];
  logic        unused_addr;
  assign unused_addr  = ^bus.addr_i[1:0];
  assign acc          = bus.req_i && gnt;
  assign in_range     = bus.addr_i[31:AW+2] == '0;
  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = pipe[RVALID_LAT-1].valid;
  assign bus.rdata_o  = pipe[RVALID_LAT-1].rdata;
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    gnt     = 1'b0;
    if (GNT_WAIT == 0) begin
      gnt     = bus.req_i && !bus.gnt_stall_i;
      state_d = IDLE;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_i) begin
          state_d = WAIT;
          wcnt_d  = '0;
        end
        WAIT: if (!bus.req_i) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == LAST && !bus.gnt_stall_i) begin
          gnt     = 1'b1;
          state_d = IDLE;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q == LAST ? wcnt_q : wcnt_q + 3'd1;
        end
      endcase
    end
  end
  cv32e40p_be_ram #(.DEPTH(MEM_DEPTH), .AW(AW)) u_ram (
    .clk_i (clk_i),
    .we    (acc && bus.we_i && in_range),
    .be    (bus.be_i),
    .addr  (bus.addr_i[AW+1:2]),
    .wdata (bus.wdata_i),
    .rdata (ram_rdata)
  );
  // Read data is captured at the grant edge; writes and idle slots carry zero data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      for (int i = 0; i < RVALID_LAT; i++) pipe[i] <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      pipe[0] <= '{valid: acc, rdata: (acc && !bus.we_i && in_range) ? ram_rdata : 32'h0};
      for (int i = 1; i < RVALID_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
`ifndef SYNTHESIS
  stable_while_waiting: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.req_i && !bus.gnt_o |=> !bus.req_i || $stable({bus.addr_i, bus.we_i, bus.be_i, bus.wdata_i}));
`endif
endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// tb_cv32e40p_obi_mem_responder: three responder configurations fed the same transaction
// list, each checked cycle by cycle against a transaction-level memory/timing model.
module tb_cv32e40p_obi_mem_responder;
  localparam int DEPTH = 16;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } tx_t;
  typedef struct {
    int          due;
    logic [31:0] d;
  } rsp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  int   gap = 0;
  int   cyc = 0;
  int   vectors = 0;
  int   misses = 0;
  tx_t  tx[$];
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(int k, string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL dut%0d %s: observed %h expected %h (cycle %0d)", k, tag, obs, exp, cyc);
    end
  endtask
  function automatic void push(logic [31:0] a, logic we, logic [3:0] be, logic [31:0] d);
    tx.push_back('{addr: a, we: we, be: be, wdata: d});
  endfunction
  function automatic tx_t rnd_tx();
    tx_t t;
    t.we    = 1'($urandom_range(1));
    t.be    = 4'($urandom_range(15));
    t.wdata = $urandom;
    t.addr  = ($urandom_range(15) == 0) ? $urandom : 32'($urandom_range(DEPTH * 4 + 15));
    return t;
  endfunction
  // Config 0: GNT_WAIT 0 / latency 1; config 1: GNT_WAIT 3 / latency 2; config 2: GNT_WAIT 0 / latency 4.
  for (genvar k = 0; k < 3; k++) begin : g
    localparam int GWK = (k == 1) ? 3 : 0;
    localparam int RLK = (k == 0) ? 1 : (k == 1) ? 2 : 4;
    cv32e40p_obi_mem_responder_if bus ();
    cv32e40p_obi_mem_responder #(.MEM_DEPTH(DEPTH), .GNT_WAIT(GWK), .RVALID_LAT(RLK)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
    );
    assign bus.gnt_stall_i = stall;
    int          p = 0;
    int          c = 0;
    bit          done = 1'b0;
    logic        granted = 1'b0;
    rsp_t        eq[$];
    logic [31:0] mem [DEPTH];
    initial begin
      logic        eg, ev;
      logic [31:0] ed, d;
      rsp_t        r;
      int unsigned w;
      bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          eq.delete();
          c = 0;
          bus.req_i = 1'b0;
        end else if (granted || !bus.req_i) begin
          bus.req_i = 1'b0;
          if (p < tx.size() && $urandom_range(99) >= gap) begin
            bus.req_i = 1'b1; bus.addr_i = tx[p].addr; bus.we_i = tx[p].we;
            bus.be_i = tx[p].be; bus.wdata_i = tx[p].wdata;
          end
        end
        granted = 1'b0;
        #1;
        // A request is granted once it has waited GNT_WAIT cycles and the stall is low.
        eg = rst_n && bus.req_i && !stall && c >= GWK;
        chk(k, "gnt", 32'(bus.gnt_o), 32'(eg));
        if (eq.size() > 0 && eq[0].due == cyc) begin
          r = eq.pop_front(); ev = 1'b1; ed = r.d;
        end else begin
          ev = 1'b0; ed = 32'h0;
        end
        chk(k, "rvalid", 32'(bus.rvalid_o), 32'(ev));
        chk(k, "rdata", bus.rdata_o, ed);
        if (eg) begin
          w = bus.addr_i >> 2;
          d = 32'h0;
          if (bus.addr_i < 32'(DEPTH * 4)) begin
            if (bus.we_i) begin
              for (int b = 0; b < 4; b++) if (bus.be_i[b]) mem[w][8*b +: 8] = bus.wdata_i[8*b +: 8];
            end else d = mem[w];
          end
          eq.push_back('{due: cyc + RLK, d: d});
          p++;
          granted = 1'b1;
          c = 0;
        end else c = bus.req_i ? c + 1 : 0;
        done = (p == tx.size()) && (eq.size() == 0);
      end
    end
  end
  function automatic bit all_done();
    return g[0].done && g[1].done && g[2].done && g[0].p == tx.size() && g[1].p == tx.size() && g[2].p == tx.size();
  endfunction
  task automatic wait_all(string tag, int budget);
    int n = 0;
    while (!all_done() && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    vectors++;
    assert (all_done()) else begin
      misses++;
      $error("FAIL drain %s: observed pending after %0d cycles, expected all responses", tag, budget);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(32'(i * 4), 1'b1, 4'hF, $urandom);
    push(32'h10, 1'b1, 4'hF, 32'h1234_5678);
    push(32'h10, 1'b0, 4'h0, 32'h0);
    push(32'h10, 1'b1, 4'b0101, 32'hAABB_CCDD);
    push(32'h12, 1'b0, 4'h0, 32'h0);
    push(32'(DEPTH * 4), 1'b1, 4'hF, 32'hDEAD_BEEF);
    push(32'(DEPTH * 4), 1'b0, 4'h0, 32'h0);
    push(32'h0, 1'b0, 4'h0, 32'h0);
    push(32'hFFFF_FFF3, 1'b0, 4'h0, 32'h0);
    wait_all("directed", 3000);
    for (int i = 0; i < 12; i++) push(32'(i * 4 + i % 4), 1'b0, 4'h0, 32'h0);
    wait_all("stream", 3000);
    for (int i = 0; i < 3; i++) push(32'(i * 8), 1'b0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    #2 stall = 1'b1;
    repeat (5) @(posedge clk);
    #2 stall = 1'b0;
    wait_all("stall", 3000);
    gap = 30;
    for (int i = 0; i < 150; i++) tx.push_back(rnd_tx());
    for (int n = 0; n < 4000 && !all_done(); n++) begin
      @(posedge clk);
      #2 stall = ($urandom_range(7) == 0);
    end
    stall = 1'b0;
    wait_all("random", 200);
    gap = 0;
    for (int i = 0; i < 6; i++) push(32'(i * 4), 1'b0, 4'h0, 32'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_all("reset", 3000);
    for (int i = 0; i < DEPTH; i++) push(32'(i * 4), 1'b0, 4'h0, 32'h0);
    wait_all("retained", 3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule

// File: doc/cv32e40p_obi_mem_responder.md
CV32E40P_OBI_MEM_RESPONDER -- requirements
Module: cv32e40p_obi_mem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, meaning the memory size in 32-bit words; it SHALL be a power of two and at least 4.
REQ-002 SHALL have parameter GNT_WAIT, default 0, meaning the number of cycles `req_i` is held before `gnt_o`; legal range 0..7.
REQ-003 SHALL have parameter RVALID_LAT, default 1, meaning the number of cycles from the grant edge to `rvalid_o`; legal range 1..4.
REQ-004 SHALL have port `clk_i`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port `rst_ni`, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port `req_i`, input, 1 bit: request from the core.
REQ-007 SHALL have port `gnt_o`, output, 1 bit: grant; the transfer is accepted when `req_i && gnt_o`.
REQ-008 SHALL have port `addr_i`, input, 32 bits: byte address.
REQ-009 SHALL have port `we_i`, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port `be_i`, input, 4 bits: byte enables for writes.
REQ-011 SHALL have port `wdata_i`, input, 32 bits: write data.
REQ-012 SHALL have port `rvalid_o`, output, 1 bit: response valid for one cycle; there is no ready, so the core always accepts.
REQ-013 SHALL have port `rdata_o`, output, 32 bits: read data, qualified by `rvalid_o`.
REQ-014 SHALL have port `gnt_stall_i`, input, 1 bit: bench-driven extra wait; while high, `gnt_o` is 0.

Function
REQ-015 Grant FSM SHALL have states IDLE and WAIT, plus a 3-bit wait counter `wcnt`.
REQ-016 With GNT_WAIT=0, `gnt_o` SHALL equal `req_i && !gnt_stall_i` combinationally, and the FSM SHALL stay in IDLE.
REQ-017 For GNT_WAIT>0, the FSM SHALL move IDLE->WAIT on `req_i`, with `wcnt` reset to 0.
REQ-018 For GNT_WAIT>0, `wcnt` SHALL increment each WAIT cycle while `req_i` is high.
REQ-019 For GNT_WAIT>0, `gnt_o` SHALL assert when `wcnt == GNT_WAIT-1 && !gnt_stall_i`, and `wcnt` SHALL saturate while stalled.
REQ-020 After a grant, the FSM SHALL return to IDLE; back-to-back requests SHALL then each pay GNT_WAIT cycles.
REQ-021 If `req_i` drops in WAIT (protocol violation), the FSM SHALL return to IDLE, clear `wcnt`, and record no transfer.
REQ-022 Word index SHALL be `addr_i[log2(MEM_DEPTH)+1:2]`; `addr_i[1:0]` SHALL be ignored.
REQ-023 Addresses at or above MEM_DEPTH*4 SHALL be out of range: writes dropped, reads return 32'h0.
REQ-024 An accepted write SHALL update only the bytes enabled by `be_i`, taking effect at the grant edge.
REQ-025 An accepted read SHALL sample memory at the grant edge, so a read granted the cycle after a write SHALL return the new data.
REQ-026 The response pipeline SHALL be a RVALID_LAT-deep shift register of {valid, data}.
REQ-027 `rvalid_o` SHALL assert exactly RVALID_LAT cycles after the grant edge, for every accepted transfer, read or write.
REQ-028 Responses SHALL be in order; up to RVALID_LAT transfers may be outstanding, one accepted per cycle maximum.
REQ-029 `rdata_o` SHALL be 32'h0 for write responses and whenever `rvalid_o` is 0.

Reset
REQ-030 On `rst_ni` low, the FSM SHALL go to IDLE, `wcnt` to 0, and all pipeline valid/data stages to 0, so `gnt_o`, `rvalid_o` and `rdata_o` read 0.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 Reset asserted mid-transfer SHALL discard all outstanding responses; none SHALL appear after reset release.

Structure
REQ-033 The state enum (IDLE, WAIT) SHALL live in cv32e40p_pkg.
REQ-034 The OBI response record type {valid, rdata} SHALL live in cv32e40p_pkg.
REQ-035 The byte-enabled storage array SHALL be a sub-module, cv32e40p_be_ram, with 1 read/write port, write-first behaviour and no reset.
REQ-036 The design SHALL include an assertion that `addr_i`, `we_i`, `be_i` and `wdata_i` are stable while `req_i && !gnt_o`, present in simulation only.

Verification
REQ-037 GNT_WAIT=0, RVALID_LAT=1: write 0x12345678 to 0x10 with be=4'hF, then read 0x10 on the next cycle -> both granted in their request cycle, and the read's `rvalid_o` comes 1 cycle after grant with `rdata_o`=0x12345678.
REQ-038 Byte enables: write 0xAABBCCDD with be=4'b0101 over prior 0x12345678 -> a subsequent read returns 0x12BB56DD.
REQ-039 GNT_WAIT=3, RVALID_LAT=2: 4 back-to-back reads -> each `gnt_o` asserts 3 cycles after `req_i` rises, and 4 `rvalid_o` pulses occur in order, each 2 cycles after its grant.
REQ-040 RVALID_LAT=4, GNT_WAIT=0: reads streamed every cycle -> 4 outstanding, `rvalid_o` high continuously, data matching address order.
REQ-041 `gnt_stall_i` high for 5 cycles during WAIT -> no grant, `wcnt` saturated; grant asserts in the first cycle after stall release.
REQ-042 Reset pulsed with 2 reads outstanding -> `rvalid_o` stays 0 after release, the FSM is in IDLE, and the memory still holds the prior writes.
REQ-043 Out-of-range: write to MEM_DEPTH*4 then read it -> `rvalid_o` is returned, `rdata_o`=0, and word 0 is unchanged.
